// File: rtl/syzygy_adc_pkg.sv
// ============================================================================
// syzygy_adc_pkg : shared types and constants for the SYZYGY ADC lane logic.
// Rev 1.0
// ============================================================================
`default_nettype none

package syzygy_adc_pkg;

  localparam int         ALIGN_DIN_WIDTH = 8;
  localparam logic [7:0] ALIGN_PATTERN   = 8'hF0;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] CHECK  = 3'd2;
  localparam logic [2:0] LOCKED = 3'd3;
  localparam logic [2:0] FAIL   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_SETTLE = SETTLE,
    ST_CHECK  = CHECK,
    ST_LOCKED = LOCKED,
    ST_FAIL   = FAIL
  } align_state_e;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bitslip_align_ctrl_if.sv
// ============================================================================
// bitslip_align_ctrl_if : lane-side bundle between shifter and align controller.
// Rev 1.0   (err_count present only when ALIGN_STATS_EN is defined)
// ============================================================================
`default_nettype none

interface bitslip_align_ctrl_if
  import syzygy_adc_pkg::*;
#(
  parameter int DIN_WIDTH = ALIGN_DIN_WIDTH
);
  localparam int CW = (DIN_WIDTH > 1) ? $clog2(DIN_WIDTH) : 1;

  logic                 enable;
  logic [DIN_WIDTH-1:0] din;
  logic [CW-1:0]        bitslip_count;
  logic                 locked;
  logic                 align_fail;
`ifdef ALIGN_STATS_EN
  logic [15:0]          err_count;
`endif

  modport master (
    output enable,
    output din,
    input  bitslip_count,
    input  locked,
`ifdef ALIGN_STATS_EN
    input  err_count,
`endif
    input  align_fail
  );

  modport slave (
    input  enable,
    input  din,
    output bitslip_count,
    output locked,
`ifdef ALIGN_STATS_EN
    output err_count,
`endif
    output align_fail
  );

endinterface

`default_nettype wire

// File: rtl/bitslip_align_ctrl.sv
// ============================================================================
// bitslip_align_ctrl : closed-loop bitslip search, lock and loss-of-lock tracking.
// Rev 1.0   (ALIGN_STATS_EN adds a saturating err_count)
// ============================================================================
`default_nettype none

module bitslip_align_ctrl
  import syzygy_adc_pkg::*;
#(
  parameter int                   DIN_WIDTH     = ALIGN_DIN_WIDTH,
  parameter logic [DIN_WIDTH-1:0] PATTERN       = DIN_WIDTH'(ALIGN_PATTERN),
  parameter int                   SETTLE_CYCLES = 4,
  parameter int                   LOCK_COUNT    = 16,
  parameter int                   UNLOCK_COUNT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bitslip_align_ctrl_if.slave  ctrl
);

  localparam int CW = (DIN_WIDTH > 1) ? $clog2(DIN_WIDTH) : 1;
  localparam int SW = cnt_width(SETTLE_CYCLES);
  localparam int MW = cnt_width(LOCK_COUNT);
  localparam int UW = cnt_width(UNLOCK_COUNT);
  localparam int TW = cnt_width(DIN_WIDTH);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] MATCH_FULL  = MW'(LOCK_COUNT);
  localparam logic [UW-1:0] MISS_LAST   = UW'(UNLOCK_COUNT - 1);
  localparam logic [TW-1:0] SLIPS_LAST  = TW'(DIN_WIDTH - 1);
  localparam logic [CW-1:0] SLIP_MAX    = CW'(DIN_WIDTH - 1);

  align_state_e  state_q, state_d;
  logic [CW-1:0] bitslip_q, bitslip_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [MW-1:0] match_q, match_d;
  logic [UW-1:0] miss_q, miss_d;
  logic [TW-1:0] slips_q, slips_d;
  logic          locked_q, align_fail_q;
  logic          w_match;

  assign w_match = (ctrl.din == PATTERN);

  always_comb begin
    state_d   = state_q;
    bitslip_d = bitslip_q;
    settle_d  = settle_q;
    match_d   = match_q;
    miss_d    = miss_q;
    slips_d   = slips_q;

    if (!ctrl.enable) begin
      state_d  = ST_IDLE;
      settle_d = '0;
      match_d  = '0;
      miss_d   = '0;
      slips_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_SETTLE;
          settle_d = '0;
          slips_d  = '0;
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d = ST_CHECK;
            match_d = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_match) begin
            if (match_q == MATCH_LAST) begin
              state_d = ST_LOCKED;
              match_d = MATCH_FULL;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d   = '0;
            settle_d  = '0;
            slips_d   = slips_q + 1'b1;
            bitslip_d = (bitslip_q == SLIP_MAX) ? '0 : bitslip_q + 1'b1;
            state_d   = (slips_q == SLIPS_LAST) ? ST_FAIL : ST_SETTLE;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            miss_d = '0;
          end else if (miss_q == MISS_LAST) begin
            // Re-search starts from the slip position that last held lock.
            state_d  = ST_SETTLE;
            miss_d   = '0;
            settle_d = '0;
            slips_d  = '0;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bitslip_q    <= '0;
      settle_q     <= '0;
      match_q      <= '0;
      miss_q       <= '0;
      slips_q      <= '0;
      locked_q     <= 1'b0;
      align_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitslip_q    <= bitslip_d;
      settle_q     <= settle_d;
      match_q      <= match_d;
      miss_q       <= miss_d;
      slips_q      <= slips_d;
      locked_q     <= (state_d == ST_LOCKED);
      align_fail_q <= (state_d == ST_FAIL);
    end
  end

  assign ctrl.bitslip_count = bitslip_q;
  assign ctrl.locked        = locked_q;
  assign ctrl.align_fail    = align_fail_q;

`ifdef ALIGN_STATS_EN
  logic [15:0] err_count_q, err_count_d;

  // Survives enable toggles and re-alignment; only rst clears it.
  always_comb begin
    err_count_d = err_count_q;
    if (ctrl.enable && (state_q == ST_LOCKED) && !w_match && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign ctrl.err_count = err_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bitslip_align_ctrl.sv
// Closed-loop bench: shifter model feeds the controller; expected output events are
// queued by a timing model of the alignment rules and checked by an output monitor.
`default_nettype none

module tb_bitslip_align_ctrl;

  localparam int         DW  = 8;
  localparam logic [7:0] PAT = 8'hF0;
  localparam int         BIG = 1 << 30;

  typedef struct {
    int kind;   // 0 bitslip_count, 1 align_fail, 2 locked
    int val;
    int cyc;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       corrupt;
  int         cmode;
  logic [7:0] raw_word;
  logic [7:0] sh_dout;
  logic [2:0] cnt_d1;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  bit  mon_en = 0;
  int  p_cnt, p_fail, p_lock;
  int  m_cnt, m_locked, m_fail, m_err, cur_k;
  ev_t exp_q[$];

  bitslip_align_ctrl_if #(.DIN_WIDTH(DW)) bus ();

  bitslip_align_ctrl #(
    .DIN_WIDTH    (DW),
    .PATTERN      (PAT),
    .SETTLE_CYCLES(4),
    .LOCK_COUNT   (16),
    .UNLOCK_COUNT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctrl(bus)
  );

  function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
    logic [7:0] r = w;
    for (int i = 0; i < (n % 8); i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] w, input int n);
    logic [7:0] r = w;
    for (int i = 0; i < (n % 8); i++) r = {r[0], r[7:1]};
    return r;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shifter model: two-cycle latency from bitslip_count to dout.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    cnt_d1  <= bus.bitslip_count;
    sh_dout <= rotr(raw_word, int'(cnt_d1));
  end

  assign bus.enable = enable;
  assign bus.din    = (cmode == 1) ? 8'h00 : (corrupt ? ~PAT : sh_dout);

  function automatic void push(input int kind, input int val, input int t);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = t;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ev(input int kind, input int val);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: kind=%0d val=%0d cyc=%0d, expected no event", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        miscompares++;
        $display("FAIL event: got kind=%0d val=%0d cyc=%0d, expected kind=%0d val=%0d cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(bus.bitslip_count) != p_cnt) check_ev(0, int'(bus.bitslip_count));
      if (int'(bus.align_fail) != p_fail)   check_ev(1, int'(bus.align_fail));
      if (int'(bus.locked) != p_lock)       check_ev(2, int'(bus.locked));
    end
    p_cnt  = int'(bus.bitslip_count);
    p_fail = int'(bus.align_fail);
    p_lock = int'(bus.locked);
  end

  // Search timeline: first CHECK sample 5 edges after SETTLE entry, one slip per
  // 5 edges on mismatch, lock 16 samples after the first matching sample.
  task automatic model_search(input int k, input int mode, input int e0, input int stop);
    int         c;
    int         t;
    logic [7:0] w;
    c = m_cnt;
    t = e0 + 5;
    for (int i = 0; i < DW; i++) begin
      w = (mode == 1) ? 8'h00 : rotr(rotl(PAT, k), c);
      if (w == PAT) begin
        if (t + 15 < stop) begin
          push(2, 1, t + 15);
          m_locked = 1;
        end
        break;
      end
      if (t >= stop) break;
      c = (c + 1) % DW;
      push(0, c, t);
      m_cnt = c;
      if (i == DW - 1) begin
        push(1, 1, t);
        m_fail = 1;
      end
      t += 5;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected events missing, next kind=%0d val=%0d cyc=%0d",
               exp_q.size(), exp_q[0].kind, exp_q[0].val, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic disable_ctrl();
    int e;
    @(negedge clk);
    e = cyc + 1;
    if (m_locked != 0) push(2, 0, e);
    if (m_fail != 0)   push(1, 0, e);
    m_locked = 0;
    m_fail   = 0;
    enable   = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // stop_rel > 0 drops enable at edge e0+stop_rel.
  task automatic start_search(input int k, input int mode, input int stop_rel);
    int e0;
    @(negedge clk);
    cur_k    = k;
    cmode    = mode;
    raw_word = rotl(PAT, k);
    repeat (4) @(negedge clk);
    e0     = cyc + 1;
    enable = 1'b1;
    model_search(k, mode, e0, (stop_rel > 0) ? e0 + stop_rel : BIG);
    if (stop_rel > 0) begin
      while (cyc < e0 + stop_rel - 1) @(negedge clk);
      if (m_locked != 0) push(2, 0, e0 + stop_rel);
      if (m_fail != 0)   push(1, 0, e0 + stop_rel);
      m_locked = 0;
      m_fail   = 0;
      enable   = 1'b0;
    end
  endtask

  // Bit i of mask = 1 corrupts the word seen on the i-th cycle while locked.
  task automatic apply_pattern(input logic [31:0] mask, input int len);
    int run = 0;
    int e;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      e = cyc + 1;
      corrupt = mask[i];
      if (mask[i]) begin
        if (m_err < 65535) m_err++;
        run++;
        if (run == 4) begin
          push(2, 0, e);
          m_locked = 0;
          model_search(cur_k, 0, e, BIG);
          break;
        end
      end else begin
        run = 0;
      end
    end
    @(negedge clk);
    corrupt = 1'b0;
  endtask

  task automatic check_err(input string name);
`ifdef ALIGN_STATS_EN
    chk(name, int'(bus.err_count), m_err);
`else
    if (name.len() == 0) $display("unused");
`endif
  endtask

  initial begin
    int k;
    int mode;
    int e;
    rst      = 1'b1;
    enable   = 1'b0;
    corrupt  = 1'b0;
    cmode    = 0;
    raw_word = PAT;
    m_cnt    = 0;
    m_locked = 0;
    m_fail   = 0;
    m_err    = 0;
    cur_k    = 0;
    repeat (4) @(negedge clk);
    chk("reset_count", int'(bus.bitslip_count), 0);
    chk("reset_locked", int'(bus.locked), 0);
    chk("reset_fail", int'(bus.align_fail), 0);
    check_err("reset_err");
    rst    = 1'b0;
    mon_en = 1'b1;

    // Already aligned: no slips, lock after settle + 16 matches.
    start_search(0, 0, 0);
    drain(200);
    chk("k0_locked", int'(bus.locked), 1);
    chk("k0_count", int'(bus.bitslip_count), 0);
    disable_ctrl();

    // Five slips to reach alignment.
    start_search(5, 0, 0);
    drain(200);
    chk("k5_locked", int'(bus.locked), 1);
    chk("k5_count", int'(bus.bitslip_count), 5);

    // Ten isolated errors while locked, then survive a re-enable.
    apply_pattern(32'h0005_5555, 20);
    drain(200);
    chk("iso_err_locked", int'(bus.locked), 1);
    check_err("err_after_10");
    disable_ctrl();
    start_search(5, 0, 0);
    drain(200);
    check_err("err_after_reenable");

    // Three bad + one good holds lock; four bad in a row drops and re-locks.
    apply_pattern(32'h0000_00F7, 8);
    drain(200);
    chk("relock_locked", int'(bus.locked), 1);
    chk("relock_count", int'(bus.bitslip_count), 5);
    check_err("err_after_unlock");
    disable_ctrl();

    // Constant zero input: all eight positions fail, count wraps back.
    start_search(0, 1, 0);
    drain(200);
    chk("fail_flag", int'(bus.align_fail), 1);
    chk("fail_locked", int'(bus.locked), 0);
    chk("fail_count", int'(bus.bitslip_count), 5);
    disable_ctrl();
    chk("fail_cleared", int'(bus.align_fail), 0);

    // Drop enable in the middle of a matching CHECK window; count must hold.
    k = (m_cnt + 2) % DW;
    start_search(k, 0, 18);
    repeat (3) @(negedge clk);
    chk("drop_count", int'(bus.bitslip_count), m_cnt);
    start_search(k, 0, 0);
    drain(200);
    chk("drop_relock", int'(bus.locked), 1);

    // Reset while locked.
    @(negedge clk);
    e   = cyc + 1;
    rst = 1'b1;
    enable = 1'b0;
    if (m_cnt != 0) push(0, 0, e);
    push(2, 0, e);
    m_cnt    = 0;
    m_locked = 0;
    m_err    = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_count", int'(bus.bitslip_count), 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_fail", int'(bus.align_fail), 0);
    check_err("rst_err");
    drain(10);

    // Randomized searches and error bursts.
    for (int it = 0; it < 10; it++) begin
      k    = $urandom_range(0, DW - 1);
      mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
      start_search(k, mode, 0);
      drain(300);
      chk("rand_locked", int'(bus.locked), m_locked);
      chk("rand_fail", int'(bus.align_fail), m_fail);
      if (m_locked != 0) begin
        apply_pattern($urandom & $urandom, 24);
        drain(300);
        chk("rand_post_err_locked", int'(bus.locked), m_locked);
      end
      chk("rand_count", int'(bus.bitslip_count), m_cnt);
      check_err("rand_err");
      disable_ctrl();
    end

    repeat (10) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL leftover: %0d events, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation bound reached at cyc %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule

`default_nettype wire
